truth_table_sweeper: RTL and testbench

- Hardware sequencer that exhaustively drives a 4-input combinational block (inputs a,b,c,d; output x) through all 16 input vectors in ascending binary order, a as MSB.
- Holds each vector for a programmable dwell, samples x at the end of the dwell and checks it against a 16-bit expected truth table latched at start.
- Reports pass/fail, mismatch count, first failing index and the full captured table.
- Replaces hand-written exhaustive stimulus for the team's gate/behavioural logic variants and can run on-chip.

---
 rtl/truth_table_sweeper.sv | 119 +++++++++++
 tb/tb_truth_table_sweeper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper. It steps {a,b,c,d} through 0..15, holds each
// vector for DWELL cycles, then samples x_in and checks it against the latched table.
module truth_table_sweeper #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        x_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic [15:0] captured
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      r_state;
  logic [15:0] r_exp;
  logic [3:0]  r_idx;
  logic [7:0]  r_dwell;
  logic [3:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_mcnt;
  logic [3:0]  r_ffi;
  logic [15:0] r_cap;

  logic w_sample;
  logic w_miss;

  assign w_sample = (r_dwell == LAST);
  assign w_miss   = (x_in != r_exp[r_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_exp   <= '0;
      r_idx   <= '0;
      r_dwell <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mcnt  <= '0;
      r_ffi   <= '0;
      r_cap   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= DRIVE;
            r_exp   <= expected;
            r_idx   <= '0;
            r_dwell <= '0;
            r_vec   <= '0;
            r_mcnt  <= '0;
            r_ffi   <= '0;
            r_cap   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        DRIVE: begin
          // Abort takes priority, so a coincident final sample is dropped.
          if (abort) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dwell <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_dwell <= r_dwell + 8'd1;
            if (w_sample) begin
              r_cap[r_idx] <= x_in;
              if (w_miss) begin
                r_mcnt <= r_mcnt + 5'd1;
                if (r_mcnt == 5'd0) r_ffi <= r_idx;
              end
              r_dwell <= '0;
              if (r_idx == 4'd15) begin
                r_state <= DONE;
                r_vec   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= (r_mcnt == 5'd0) && !w_miss;
              end else begin
                r_idx <= r_idx + 4'd1;
                r_vec <= r_idx + 4'd1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {a, b, c, d}   = r_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign mismatch_cnt   = r_mcnt;
  assign first_fail_idx = r_ffi;
  assign captured       = r_cap;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: each start pushes the expected result, and a monitor checks it on the rising edge of done.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DWELL=4 instance
  logic        start0 = 0, abort0 = 0, x0;
  logic [15:0] exp0 = '0;
  logic [1:0]  mode0 = '0;
  logic        a0, b0, c0, d0, busy0, done0, pass0;
  logic [4:0]  mc0;
  logic [3:0]  ff0;
  logic [15:0] cap0;

  always_comb begin
    x0 = 1'b0;
    case (mode0)
      2'd0: x0 = a0 & b0;
      2'd2: x0 = d0;         // x = d marks the odd indices: captured = AAAA
      default: x0 = 1'b0;
    endcase
  end

  truth_table_sweeper #(.DWELL(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0), .x_in(x0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_cnt(mc0), .first_fail_idx(ff0), .captured(cap0));

  // DWELL=1 instance, parity under test
  logic        start1 = 0, abort1 = 0, x1;
  logic [15:0] exp1 = '0;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic [4:0]  mc1;
  logic [3:0]  ff1;
  logic [15:0] cap1;

  assign x1 = a1 ^ b1 ^ c1 ^ d1;

  truth_table_sweeper #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1), .x_in(x1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_cnt(mc1), .first_fail_idx(ff1), .captured(cap1));

  typedef struct {
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  ffi;
    logic [15:0] cap;
    int          lat;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  int t0s = 0, t1s = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic res_t mk(input logic p, input logic [4:0] n, input logic [3:0] f,
                              input logic [15:0] cp, input int l);
    res_t r;
    r.pass = p; r.cnt = n; r.ffi = f; r.cap = cp; r.lat = l;
    return r;
  endfunction

  // Monitors: compare on every rising edge of done
  logic pd0 = 0, pd1 = 0;
  always @(negedge clk) begin
    res_t e;
    if (done0 && !pd0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_pass", pass0, e.pass);
        chk("u0_mismatch_cnt", mc0, e.cnt);
        chk("u0_first_fail", ff0, e.ffi);
        chk("u0_captured", cap0, e.cap);
        chk("u0_latency", cyc - t0s, e.lat);
        chk("u0_busy_at_done", busy0, 0);
      end
    end
    pd0 = done0;
  end

  always @(negedge clk) begin
    res_t e;
    if (done1 && !pd1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_pass", pass1, e.pass);
        chk("u1_mismatch_cnt", mc1, e.cnt);
        chk("u1_captured", cap1, e.cap);
        chk("u1_latency", cyc - t1s, e.lat);
      end
    end
    pd1 = done1;
  end

  task automatic go0(input logic [15:0] e, input logic [1:0] m);
    @(negedge clk);
    mode0 = m; exp0 = e; start0 = 1'b1; t0s = cyc;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int bound);
    int n = 0;
    while (!done0 && n < bound) begin @(negedge clk); n++; end
    chk("u0_done_seen", done0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_vec", {a0, b0, c0, d0}, 0);
    chk("rst_mc", mc0, 0);
    chk("rst_ff", ff0, 0);
    chk("rst_cap", cap0, 0);
    rst_n = 1'b1;

    // a&b against F000, with the vector order and dwell checked cycle by cycle
    q0.push_back(mk(1, 0, 0, 16'hF000, 65));
    go0(16'hF000, 2'd0);
    for (int k = 0; k < 64; k++) begin
      chk("vec_step", {a0, b0, c0, d0}, k / 4);
      chk("busy_step", busy0, 1);
      @(negedge clk);
    end
    wait_done0(5);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_in_done_done", done0, 1);
    chk("abort_in_done_pass", pass0, 1);

    // x tied low against 8001
    q0.push_back(mk(0, 2, 0, 16'h0000, 65));
    go0(16'h8001, 2'd1);
    wait_done0(80);

    // every vector wrong; expected is changed mid-sweep and must be ignored
    q0.push_back(mk(0, 16, 0, 16'hAAAA, 65));
    go0(16'h5555, 2'd2);
    repeat (10) @(negedge clk);
    exp0 = 16'h0000;
    wait_done0(80);

    // DWELL=1 parity, with a start pulse mid-sweep that must be ignored
    q1.push_back(mk(1, 0, 0, 16'h6996, 17));
    @(negedge clk);
    exp1 = 16'h6996; start1 = 1'b1; t1s = cyc;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 30 && !done1; n++) @(negedge clk);
    chk("u1_done_seen", done1, 1);
    @(negedge clk);

    // abort on the cycle of the idx=15 sample
    go0(16'hF000, 2'd0);
    repeat (63) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_pass", pass0, 0);
    chk("abort_vec", {a0, b0, c0, d0}, 0);
    chk("abort_cap_partial", cap0, 16'h7000);
    chk("abort_mc", mc0, 0);
    repeat (3) @(negedge clk);
    q0.push_back(mk(1, 0, 0, 16'hF000, 65));
    go0(16'hF000, 2'd0);
    chk("restart_cap_clear", cap0, 0);
    chk("restart_busy", busy0, 1);
    wait_done0(80);

    // reset asserted at idx=7
    go0(16'h8001, 2'd1);
    repeat (29) @(negedge clk);
    chk("mid_vec7", {a0, b0, c0, d0}, 7);
    chk("mid_mc", mc0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    chk("arst_vec", {a0, b0, c0, d0}, 0);
    chk("arst_mc", mc0, 0);
    chk("arst_cap", cap0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(mk(1, 0, 0, 16'hF000, 65));
    go0(16'hF000, 2'd0);
    chk("post_rst_vec0", {a0, b0, c0, d0}, 0);
    wait_done0(80);

    chk("u0_queue_empty", q0.size(), 0);
    chk("u1_queue_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
